// File: rtl/mem_bist_pkg.sv
// Shared types and default sizing for the memory BIST controller and its bench.
// MEM_BIST_INV_PASS_EN adds the inverted-pattern write/read states.
package mem_bist_pkg;

  localparam int unsigned BIST_ADDR_WIDTH = 4;
  localparam int unsigned BIST_DATA_WIDTH = 8;
  localparam int unsigned BIST_DEPTH      = 16;
  localparam int unsigned BIST_ERR_WIDTH  = 8;

  typedef enum logic [2:0] {
    IDLE,
    WRITE,
    READ,
    FIN
`ifdef MEM_BIST_INV_PASS_EN
    ,
    WRITE_INV,
    READ_INV
`endif
  } bist_state_t;

endpackage

// File: rtl/mem_bist_pattern.sv
// Combinational test pattern: address zero-extended, XOR seed, optionally inverted.
module mem_bist_pattern #(
  parameter int unsigned ADDR_WIDTH = 4,
  parameter int unsigned DATA_WIDTH = 8
) (
  input  logic [ADDR_WIDTH-1:0] addr,
  input  logic [DATA_WIDTH-1:0] seed,
  input  logic                  inv,
  output logic [DATA_WIDTH-1:0] pattern_c
);

  logic [DATA_WIDTH-1:0] base_c;

  always_comb begin
    base_c    = DATA_WIDTH'(addr) ^ seed;
    pattern_c = inv ? ~base_c : base_c;
  end

endmodule

// File: rtl/mem_bist_ctrl.sv
// March-style memory BIST: write address^seed, read back and compare, report result.
// Define MEM_BIST_INV_PASS_EN to append a second write/read pass with the inverted pattern.
module mem_bist_ctrl
  import mem_bist_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = BIST_ADDR_WIDTH,
  parameter int unsigned DATA_WIDTH = BIST_DATA_WIDTH,
  parameter int unsigned DEPTH      = BIST_DEPTH
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [ADDR_WIDTH:0]   num,
  input  logic [DATA_WIDTH-1:0] seed,
  output logic                  valid,
  output logic                  wr_rd,
  output logic [ADDR_WIDTH-1:0] addr,
  output logic [DATA_WIDTH-1:0] wdata,
  input  logic                  ready,
  input  logic [DATA_WIDTH-1:0] rdata,
  output logic                  busy,
  output logic                  done,
  output logic                  pass,
  output logic [7:0]            err_count,
  output logic [ADDR_WIDTH-1:0] fail_addr
);

  localparam int unsigned NW = ADDR_WIDTH + 1;

  bist_state_t           state;
  logic [NW-1:0]         num_q;
  logic [DATA_WIDTH-1:0] seed_q;

  logic [NW-1:0]         num_clamp_c;
  logic                  accept_c;
  logic                  last_c;
  logic                  mismatch_c;
  logic [ADDR_WIDTH-1:0] wr_addr_c;
  logic [DATA_WIDTH-1:0] wr_seed_c;
  logic                  wr_inv_c;
  logic                  exp_inv_c;
  logic [DATA_WIDTH-1:0] wr_pat_c;
  logic [DATA_WIDTH-1:0] exp_pat_c;

  always_comb begin
    num_clamp_c = (num > NW'(DEPTH)) ? NW'(DEPTH) : num;
    accept_c    = valid & ready;
    last_c      = ({1'b0, addr} == (num_q - NW'(1)));
    mismatch_c  = accept_c & ~wr_rd & (rdata != exp_pat_c);
  end

  // Pattern inputs for the next write data, which is loaded one step ahead of the address
  always_comb begin
    wr_addr_c = '0;
    wr_seed_c = seed_q;
    wr_inv_c  = 1'b0;
    exp_inv_c = 1'b0;
    case (state)
      IDLE:  wr_seed_c = seed;
      WRITE: wr_addr_c = addr + ADDR_WIDTH'(1);
`ifdef MEM_BIST_INV_PASS_EN
      READ:  wr_inv_c = 1'b1;
      WRITE_INV: begin
        wr_addr_c = addr + ADDR_WIDTH'(1);
        wr_inv_c  = 1'b1;
      end
      READ_INV: exp_inv_c = 1'b1;
`endif
      default: ;
    endcase
  end

  mem_bist_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_wr_pat (
    .addr      (wr_addr_c),
    .seed      (wr_seed_c),
    .inv       (wr_inv_c),
    .pattern_c (wr_pat_c)
  );

  mem_bist_pattern #(
    .ADDR_WIDTH (ADDR_WIDTH),
    .DATA_WIDTH (DATA_WIDTH)
  ) u_exp_pat (
    .addr      (addr),
    .seed      (seed_q),
    .inv       (exp_inv_c),
    .pattern_c (exp_pat_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= IDLE;
      num_q     <= '0;
      seed_q    <= '0;
      valid     <= 1'b0;
      wr_rd     <= 1'b0;
      addr      <= '0;
      wdata     <= '0;
      busy      <= 1'b0;
      done      <= 1'b0;
      pass      <= 1'b0;
      err_count <= '0;
      fail_addr <= '0;
    end else begin
      done <= 1'b0;

      // Read compare; the first miss is the one seen while the count is still zero
      if (mismatch_c) begin
        if (err_count != 8'hFF) err_count <= err_count + 8'd1;
        if (err_count == 8'd0)  fail_addr <= addr;
      end

      case (state)
        IDLE: begin
          if (start) begin
            num_q     <= num_clamp_c;
            seed_q    <= seed;
            err_count <= '0;
            fail_addr <= '0;
            pass      <= 1'b0;
            busy      <= 1'b1;
            addr      <= '0;
            if (num_clamp_c == '0) begin
              state <= FIN;
              valid <= 1'b0;
            end else begin
              state <= WRITE;
              valid <= 1'b1;
              wr_rd <= 1'b1;
              wdata <= wr_pat_c;
            end
          end
        end

        WRITE: begin
          if (accept_c) begin
            if (last_c) begin
              state <= READ;
              addr  <= '0;
              wr_rd <= 1'b0;
            end else begin
              addr  <= addr + ADDR_WIDTH'(1);
              wdata <= wr_pat_c;
            end
          end
        end

        READ: begin
          if (accept_c) begin
            if (last_c) begin
`ifdef MEM_BIST_INV_PASS_EN
              state <= WRITE_INV;
              addr  <= '0;
              wr_rd <= 1'b1;
              wdata <= wr_pat_c;
`else
              state <= FIN;
              valid <= 1'b0;
`endif
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end

`ifdef MEM_BIST_INV_PASS_EN
        WRITE_INV: begin
          if (accept_c) begin
            if (last_c) begin
              state <= READ_INV;
              addr  <= '0;
              wr_rd <= 1'b0;
            end else begin
              addr  <= addr + ADDR_WIDTH'(1);
              wdata <= wr_pat_c;
            end
          end
        end

        READ_INV: begin
          if (accept_c) begin
            if (last_c) begin
              state <= FIN;
              valid <= 1'b0;
            end else begin
              addr <= addr + ADDR_WIDTH'(1);
            end
          end
        end
`endif

        FIN: begin
          done  <= 1'b1;
          pass  <= (err_count == 8'd0);
          busy  <= 1'b0;
          valid <= 1'b0;
          state <= IDLE;
        end

        default: begin
          state <= IDLE;
          valid <= 1'b0;
          busy  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_bist_ctrl.sv
// Randomized self-checking bench for mem_bist_ctrl with a behavioural memory and result model.
// Honours MEM_BIST_INV_PASS_EN to expect the extra inverted pass.
module tb_mem_bist_ctrl;
  import mem_bist_pkg::*;

  localparam int unsigned AW    = BIST_ADDR_WIDTH;
  localparam int unsigned DW    = BIST_DATA_WIDTH;
  localparam int unsigned DEPTH = BIST_DEPTH;
`ifdef MEM_BIST_INV_PASS_EN
  localparam int NPASS = 2;
`else
  localparam int NPASS = 1;
`endif

  logic          clk = 1'b0;
  logic          rst;
  logic          start;
  logic [AW:0]   num;
  logic [DW-1:0] seed;
  logic          valid;
  logic          wr_rd;
  logic [AW-1:0] addr;
  logic [DW-1:0] wdata;
  logic          ready;
  logic [DW-1:0] rdata;
  logic          busy;
  logic          done;
  logic          pass;
  logic [7:0]    err_count;
  logic [AW-1:0] fail_addr;

  mem_bist_ctrl #(
    .ADDR_WIDTH (AW),
    .DATA_WIDTH (DW),
    .DEPTH      (DEPTH)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .num       (num),
    .seed      (seed),
    .valid     (valid),
    .wr_rd     (wr_rd),
    .addr      (addr),
    .wdata     (wdata),
    .ready     (ready),
    .rdata     (rdata),
    .busy      (busy),
    .done      (done),
    .pass      (pass),
    .err_count (err_count),
    .fail_addr (fail_addr)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural memory with an optional single-bit read fault
  logic [DW-1:0] mem [DEPTH];
  logic          fault_en;
  logic [AW-1:0] fault_addr;
  int            rmode;

  assign rdata = mem[addr] ^ DW'(fault_en && (addr == fault_addr));

  always @(posedge clk)
    if (!rst && valid && ready && wr_rd) mem[addr] <= wdata;

  // ready: 0 = tied high, 1 = toggling, other = random
  always @(posedge clk) begin
    #2;
    case (rmode)
      0:       ready = 1'b1;
      1:       ready = ~ready;
      default: ready = 1'($urandom_range(0, 1));
    endcase
  end

  typedef struct packed {
    logic          wr;
    logic [AW-1:0] a;
    logic [DW-1:0] d;
  } txn_t;

  txn_t obs_q[$];
  logic prev_stall = 1'b0;
  txn_t prev_t;

  // Transaction log plus hold-during-stall check
  always @(negedge clk) begin
    txn_t t;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        chk("hold", 32'({valid, wr_rd, addr, wdata}), 32'({1'b1, prev_t}));
      if (valid && ready) begin
        t.wr = wr_rd;
        t.a  = addr;
        t.d  = wr_rd ? wdata : '0;
        obs_q.push_back(t);
      end
      prev_stall = valid && !ready;
      prev_t.wr  = wr_rd;
      prev_t.a   = addr;
      prev_t.d   = wdata;
    end
  end

  task automatic run(input int n, input logic [DW-1:0] sd, input int mode,
                     input logic fen, input logic [AW-1:0] fa, input logic glitch);
    int            en, cyc, nerr;
    logic [DW-1:0] pat;
    txn_t          exp_q[$];
    txn_t          t;
    en         = (n > int'(DEPTH)) ? int'(DEPTH) : n;
    rmode      = mode;
    fault_en   = fen;
    fault_addr = fa;
    obs_q.delete();
    start = 1'b1;
    num   = (AW+1)'(n);
    seed  = sd;
    @(posedge clk); #1;
    start = 1'b0;
    num   = (AW+1)'($urandom);
    seed  = DW'($urandom);
    cyc   = 1;
    while (done !== 1'b1 && cyc < 3000) begin
      if (glitch && cyc == 5) begin
        start = 1'b1;
        num   = (AW+1)'(3);
      end else begin
        start = 1'b0;
      end
      @(posedge clk); #1;
      cyc++;
    end
    start = 1'b0;
    chk("done_seen", 32'(done), 32'd1);
    if (mode == 0)
      chk("cycles", 32'(cyc), 32'((en == 0) ? 2 : 2 * NPASS * en + 2));

    // Expected transaction stream and result from the test's definition
    nerr = 0;
    for (int p = 0; p < NPASS; p++) begin
      for (int i = 0; i < en; i++) begin
        pat  = DW'(i) ^ sd;
        t.wr = 1'b1;
        t.a  = AW'(i);
        t.d  = (p == 1) ? ~pat : pat;
        exp_q.push_back(t);
      end
      for (int i = 0; i < en; i++) begin
        t.wr = 1'b0;
        t.a  = AW'(i);
        t.d  = '0;
        exp_q.push_back(t);
      end
      if (fen && int'(fa) < en) nerr++;
    end

    chk("pass", 32'(pass), 32'(nerr == 0));
    chk("err_count", 32'(err_count), 32'(nerr > 255 ? 255 : nerr));
    chk("fail_addr", 32'(fail_addr), (nerr != 0) ? 32'(fa) : 32'd0);
    chk("busy_end", 32'(busy), 32'd0);
    chk("n_txn", 32'(obs_q.size()), 32'(exp_q.size()));
    for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++)
      chk($sformatf("txn%0d", i), 32'(obs_q[i]), 32'(exp_q[i]));
    @(posedge clk); #1;
    chk("done_pulse", 32'(done), 32'd0);
    chk("pass_sticky", 32'(pass), 32'(nerr == 0));
  endtask

  task automatic reset_mid();
    int wait_cyc, ndone;
    rmode      = 0;
    fault_en   = 1'b1;
    fault_addr = '0;
    start = 1'b1;
    num   = (AW+1)'(16);
    seed  = DW'(8'h3C);
    @(posedge clk); #1;
    start    = 1'b0;
    wait_cyc = 0;
    while (!(valid && !wr_rd && addr == AW'(3)) && wait_cyc < 200) begin
      @(posedge clk); #1;
      wait_cyc++;
    end
    chk("reach_read", 32'(wait_cyc < 200), 32'd1);
    chk("err_before_rst", 32'(err_count), 32'd1);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("rst_valid", 32'(valid), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    chk("rst_err", 32'(err_count), 32'd0);
    chk("rst_fail", 32'(fail_addr), 32'd0);
    chk("rst_pass", 32'(pass), 32'd0);
    rst   = 1'b0;
    ndone = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (done || valid) ndone++;
    end
    chk("no_done_after_rst", 32'(ndone), 32'd0);
    fault_en = 1'b0;
  endtask

  initial begin
    rst        = 1'b1;
    start      = 1'b0;
    num        = '0;
    seed       = '0;
    ready      = 1'b1;
    rmode      = 0;
    fault_en   = 1'b0;
    fault_addr = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst0_valid", 32'(valid), 32'd0);
    chk("rst0_outs", 32'({wr_rd, addr, wdata, busy, done, pass}), 32'd0);
    chk("rst0_res", 32'({err_count, fail_addr}), 32'd0);
    rst = 1'b0;
    @(posedge clk); #1;

    run(16, DW'(8'hA5), 0, 1'b0, AW'(0), 1'b0);
    run(16, DW'(8'h3C), 1, 1'b0, AW'(0), 1'b0);
    run(16, DW'(8'h5A), 0, 1'b1, AW'(5), 1'b0);
    run(0,  DW'(8'h11), 0, 1'b0, AW'(0), 1'b0);
    run(31, DW'(8'h77), 0, 1'b0, AW'(0), 1'b0);
    run(16, DW'(8'h12), 0, 1'b0, AW'(0), 1'b1);
    reset_mid();
    run(16, DW'(8'hA5), 0, 1'b0, AW'(0), 1'b0);
    run(4,  DW'(8'h00), 0, 1'b0, AW'(0), 1'b0);
    run(1,  DW'(8'hFF), 2, 1'b1, AW'(0), 1'b0);
    for (int k = 0; k < 12; k++)
      run($urandom_range(0, 31), DW'($urandom), $urandom_range(0, 2),
          1'($urandom_range(0, 1)), AW'($urandom), 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/mem_bist_ctrl.md
MEM_BIST_CTRL -- requirements
Module: mem_bist_ctrl

Interface
REQ-001 Parameter ADDR_WIDTH, default 4, memory address width.
REQ-002 Parameter DATA_WIDTH, default 8, memory data width.
REQ-003 Parameter DEPTH, default 16, number of addressable locations (at most 2**ADDR_WIDTH).
REQ-004 clk  input  1  single clock; all logic on the rising edge.
REQ-005 rst  input  1  synchronous, active-high reset.
REQ-006 start  input  1  one-cycle request to begin a test run.
REQ-007 num  input  ADDR_WIDTH+1  number of locations to test, sampled on an accepted start.
REQ-008 seed  input  DATA_WIDTH  pattern seed, sampled on an accepted start.
REQ-009 valid  output  1  memory request valid.
REQ-010 wr_rd  output  1  1 = write, 0 = read.
REQ-011 addr  output  ADDR_WIDTH  request address.
REQ-012 wdata  output  DATA_WIDTH  write data.
REQ-013 ready  input  1  memory accepts the request this cycle.
REQ-014 rdata  input  DATA_WIDTH  read data; valid in the cycle where valid, ready and wr_rd=0 are all high.
REQ-015 busy  output  1  run in progress.
REQ-016 done  output  1  one-cycle pulse at the end of a run.
REQ-017 pass  output  1  result of the last run; sticky until the next accepted start.
REQ-018 err_count  output  8  saturating mismatch count for the last run.
REQ-019 fail_addr  output  ADDR_WIDTH  address of the first mismatch in the last run.

Function
REQ-020 The FSM states SHALL be IDLE, WRITE, READ and FIN.
REQ-021 Start handling:
- start is accepted only in IDLE; start while busy is ignored.
- On an accepted start: latch num (clamped to DEPTH), latch seed, clear err_count, fail_addr and pass, then go to WRITE.
REQ-022 A latched num of 0 SHALL go directly to FIN with no transactions, giving pass=1 and done one cycle later.
REQ-023 WRITE state:
- Issue writes to addresses 0..num-1 in ascending order.
- wdata = addr zero-extended to DATA_WIDTH, XOR seed.
- Advance one address per cycle in which valid&ready is high.
REQ-024 While valid is high and ready is low, valid, wr_rd, addr and wdata SHALL hold stable.
REQ-025 After the write at address num-1 is accepted, the block SHALL go to READ starting at address 0.
REQ-026 READ state:
- Issue reads to 0..num-1.
- On each accepted read, compare rdata against the expected pattern.
- On a mismatch, increment err_count, saturating at 255.
- On the first mismatch, capture addr into fail_addr.
REQ-027 After the last read is accepted, go to FIN. In FIN:
- done = 1 for exactly one cycle.
- pass = (err_count == 0).
- Return to IDLE on the next cycle.
REQ-028 busy SHALL be high in every state except IDLE; valid SHALL be high only in WRITE and READ.
REQ-029 Back-to-back operation: one transaction per cycle SHALL be sustained when ready is held high, so a run with no stalls takes 2*num+2 cycles from start to done.

Reset
REQ-030 While rst is high at a clock edge, the block SHALL be in IDLE with valid, wr_rd, addr, wdata, busy, done, pass, err_count and fail_addr all 0.
REQ-031 Reset asserted mid-run SHALL abort the run: valid is 0 after that edge, no done pulse is produced, and the result outputs are cleared.

Configuration
REQ-032 When MEM_BIST_INV_PASS_EN is defined:
- After READ, the FSM SHALL add the states WRITE_INV and READ_INV, which repeat the write and read passes with the inverted pattern (~(addr^seed)).
- Errors accumulate into the same err_count and fail_addr.
- Stall-free run length becomes 4*num+2 cycles.
REQ-033 When MEM_BIST_INV_PASS_EN is undefined, the extra states and their logic SHALL be absent and READ goes directly to FIN.

Structure
REQ-034 A shared package mem_bist_pkg SHALL hold the state enum typedef and the default width and depth constants, and SHALL be shared with the memory bench.
REQ-035 A single sub-module, mem_bist_pattern, SHALL compute the expected and write pattern from addr, seed and the invert flag; it is purely combinational.

Verification
REQ-036 Clean run: seed=8'hA5, num=16, ready tied high -> 16 writes then 16 reads, done at cycle 34 after start, pass=1, err_count=0.
REQ-037 Stalls: ready toggles every other cycle -> outputs held stable during stalls, the assertion on REQ-024 never fires, pass=1.
REQ-038 Fault injection: memory model flips bit 0 at address 5 on reads, num=16 -> pass=0, err_count=1, fail_addr=5.
REQ-039 Boundaries:
- num=0 -> no valid asserted, done one cycle after FIN entry, pass=1.
- num=31 -> clamped to 16 transactions per pass.
REQ-040 Start while busy plus reset mid-run:
- start is pulsed at cycle 5 of a run -> ignored.
- rst is asserted during READ -> IDLE, valid=0, no done pulse.
- A new start after reset -> run completes normally.
REQ-041 MEM_BIST_INV_PASS_EN defined, seed=8'h00, num=4 -> writes 00..03, then reads, then writes FF..FC, then reads; done at cycle 18 after start, pass=1.
